// File: rtl/spi_sector_erase_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_sector_erase_ctrl_pkg
// Shared definitions for the SPI sector-erase controller: flash opcodes,
// the controller state enum, the per-command step enum and small helpers.
// Optional feature macro: SPI_SE_WIP_POLL_EN (adds the POLL state).
// ---------------------------------------------------------------------------
package spi_sector_erase_ctrl_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREN  = 3'd1,
    ST_DESEL = 3'd2,
    ST_SE    = 3'd3,
    ST_DONE  = 3'd4
`ifdef SPI_SE_WIP_POLL_EN
    ,
    ST_POLL  = 3'd5
`endif
  } state_e;

  // Every command runs SETUP (cs low, sclk idle), SHIFT (bytes), HOLD (cs low, sclk idle).
  typedef enum logic [1:0] {
    STEP_SETUP = 2'd0,
    STEP_SHIFT = 2'd1,
    STEP_HOLD  = 2'd2
  } step_e;

  // States in which chip select is held low.
  function automatic logic is_cmd_state(input state_e s);
    logic r;
    case (s)
      ST_WREN: r = 1'b1;
      ST_SE:   r = 1'b1;
`ifdef SPI_SE_WIP_POLL_EN
      ST_POLL: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte idx of the 4-byte sector-erase frame: opcode then address MSB first.
  function automatic logic [7:0] se_frame_byte(input logic [1:0] idx, input logic [23:0] addr);
    logic [7:0] b;
    case (idx)
      2'd0:    b = OP_SE;
      2'd1:    b = addr[23:16];
      2'd2:    b = addr[15:8];
      2'd3:    b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_sector_erase_ctrl_shifter.sv
// ---------------------------------------------------------------------------
// spi_byte_shifter
// Mode-0 SPI byte engine: 4 sys_clk per bit, 8 bits MSB first.
//   phase 0: mosi updates, sclk low; phase 1: sclk low; phases 2-3: sclk high.
// Handshake: i_start loads i_data when idle, or in the o_done cycle so that
// bytes chain back to back without a gap. o_done is high during the final
// phase 3 of a byte.
// Ports: i_clk, i_rst_n (async active low), i_start, i_data[7:0],
//        o_done, o_sclk, o_mosi; with SPI_SE_WIP_POLL_EN also i_miso and
//        o_rx[7:0] (miso sampled while sclk is high, at the end of phase 2).
// ---------------------------------------------------------------------------
module spi_byte_shifter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
`ifdef SPI_SE_WIP_POLL_EN
  input  logic       i_miso,
  output logic [7:0] o_rx,
`endif
  output logic       o_done,
  output logic       o_sclk,
  output logic       o_mosi
);

  logic       r_busy;
  logic [1:0] r_phase;
  logic [2:0] r_bit;
  logic [6:0] r_sh;      // bits still to send after the one on mosi
  logic       r_sclk;
  logic       r_mosi;
  logic       w_last;
  logic       w_load;

  assign w_last = r_busy && (r_phase == 2'd3) && (r_bit == 3'd7);
  assign w_load = i_start && (!r_busy || w_last);

  // Bit timing, shift-out and registered sclk/mosi.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy  <= 1'b0;
      r_phase <= 2'd0;
      r_bit   <= 3'd0;
      r_sh    <= 7'd0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else if (w_load) begin
      r_busy  <= 1'b1;
      r_phase <= 2'd0;
      r_bit   <= 3'd0;
      r_sh    <= i_data[6:0];
      r_sclk  <= 1'b0;
      r_mosi  <= i_data[7];
    end else if (r_busy) begin
      if (r_phase == 2'd3) begin
        r_phase <= 2'd0;
        r_sclk  <= 1'b0;
        if (r_bit == 3'd7) begin
          r_busy <= 1'b0;
          r_mosi <= 1'b0;
        end else begin
          r_bit  <= r_bit + 3'd1;
          r_sh   <= {r_sh[5:0], 1'b0};
          r_mosi <= r_sh[6];
        end
      end else begin
        r_phase <= r_phase + 2'd1;
        // entering phase 2 or 3 -> sclk high
        r_sclk  <= (r_phase != 2'd0);
      end
    end else begin
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
    end
  end

`ifdef SPI_SE_WIP_POLL_EN
  logic [7:0] r_rx;

  // Shift-in of miso while sclk is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx <= 8'h00;
    end else if (r_busy && (r_phase == 2'd2)) begin
      r_rx <= {r_rx[6:0], i_miso};
    end else begin
      r_rx <= r_rx;
    end
  end

  assign o_rx = r_rx;
`endif

  assign o_done = w_last;
  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;

endmodule

// File: rtl/spi_sector_erase_ctrl.sv
// ---------------------------------------------------------------------------
// spi_sector_erase_ctrl
// After reset release, waits START_DLY cycles, sends WREN (06), deselects for
// DESEL_CYC cycles, sends SE (D8 + 24-bit SECTOR_ADDR) and parks in DONE.
// The erase is issued once per reset; reset mid-command raises cs at once.
// Optional macro SPI_SE_WIP_POLL_EN: after SE deselect, RDSR (05) is sent
// and status bytes are clocked under one cs window until WIP (bit0) is 0.
// Ports: sys_clk (50 MHz), sys_rst_n (async active low), spi_miso (status,
//        poll build only), spi_sclk (mode 0), spi_cs (active low), spi_mosi.
// ---------------------------------------------------------------------------
module spi_sector_erase_ctrl
  import spi_sector_erase_ctrl_pkg::*;
#(
  parameter logic [23:0] SECTOR_ADDR = 24'h00_0000,
  parameter int          START_DLY   = 100,
  parameter int          DESEL_CYC   = 5
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic spi_miso,
  output logic spi_sclk,
  output logic spi_cs,
  output logic spi_mosi
);

  localparam int CNT_MAX = (START_DLY > DESEL_CYC) ? START_DLY : DESEL_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DLY - 1);
  localparam logic [CNT_W-1:0] DESEL_LAST = CNT_W'(DESEL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           r_state;
  step_e            r_step;
  logic [1:0]       r_byte;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cs;

  state_e           w_state_nxt;
  step_e            w_step_nxt;
  logic [1:0]       w_byte_nxt;
  logic [1:0]       w_byte_inc;
  logic             w_more;
  state_e           w_exit;
  logic             w_start;
  logic [7:0]       w_tx;
  logic             w_cs_d;
  logic             w_done;
  logic             w_sclk;
  logic             w_mosi;

`ifdef SPI_SE_WIP_POLL_EN
  logic [7:0]       w_rx;
  logic             r_se_sent;
`else
  logic             w_unused_miso;
  assign w_unused_miso = spi_miso;
`endif

  // State, step, byte index, delay counter and registered chip select.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_SETUP;
      r_byte  <= 2'd0;
      r_cnt   <= '0;
      r_cs    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_byte  <= w_byte_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_ONE;
      r_cs    <= w_cs_d;
    end
  end

`ifdef SPI_SE_WIP_POLL_EN
  // Remembers that SE went out, so the following deselect leads to POLL.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_se_sent <= 1'b0;
    end else if ((r_state == ST_SE) && (w_state_nxt == ST_DESEL)) begin
      r_se_sent <= 1'b1;
    end else begin
      r_se_sent <= r_se_sent;
    end
  end
`endif

  // Per-command decode: does another byte follow, and where to go after HOLD.
  always_comb begin
    w_more     = 1'b0;
    w_exit     = ST_DONE;
    w_byte_inc = r_byte + 2'd1;
    case (r_state)
      ST_WREN: begin
        w_exit = ST_DESEL;
      end
      ST_SE: begin
        w_more = (r_byte != 2'd3);
`ifdef SPI_SE_WIP_POLL_EN
        w_exit = ST_DESEL;
`else
        w_exit = ST_DONE;
`endif
      end
`ifdef SPI_SE_WIP_POLL_EN
      ST_POLL: begin
        // byte 0 is the opcode; afterwards keep reading while WIP is set
        w_more     = (r_byte == 2'd0) || w_rx[0];
        w_exit     = ST_DONE;
        w_byte_inc = 2'd1;
      end
`endif
      default: begin
        w_more = 1'b0;
        w_exit = ST_DONE;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_byte_nxt  = r_byte;
    case (r_state)
      ST_IDLE: begin
        if (r_cnt == START_LAST) begin
          w_state_nxt = ST_WREN;
          w_step_nxt  = STEP_SETUP;
          w_byte_nxt  = 2'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DESEL: begin
        if (r_cnt == DESEL_LAST) begin
`ifdef SPI_SE_WIP_POLL_EN
          w_state_nxt = r_se_sent ? ST_POLL : ST_SE;
`else
          w_state_nxt = ST_SE;
`endif
          w_step_nxt  = STEP_SETUP;
          w_byte_nxt  = 2'd0;
        end else begin
          w_state_nxt = ST_DESEL;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        if (is_cmd_state(r_state)) begin
          case (r_step)
            STEP_SETUP: w_step_nxt = STEP_SHIFT;
            STEP_SHIFT: begin
              if (w_done && w_more) begin
                w_byte_nxt = w_byte_inc;
              end else if (w_done) begin
                w_step_nxt = STEP_HOLD;
              end else begin
                w_step_nxt = STEP_SHIFT;
              end
            end
            STEP_HOLD: begin
              w_state_nxt = w_exit;
              w_step_nxt  = STEP_SETUP;
              w_byte_nxt  = 2'd0;
            end
            default: w_step_nxt = STEP_SETUP;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Output decode: shifter start/data and next chip-select level.
  always_comb begin
    w_start = 1'b0;
    w_tx    = 8'h00;
    if (is_cmd_state(r_state)) begin
      w_start = (r_step == STEP_SETUP) || ((r_step == STEP_SHIFT) && w_done && w_more);
    end else begin
      w_start = 1'b0;
    end
    case (r_state)
      ST_WREN: w_tx = OP_WREN;
      // w_byte_nxt is the index of the byte being loaded this cycle
      ST_SE:   w_tx = se_frame_byte(w_byte_nxt, SECTOR_ADDR);
`ifdef SPI_SE_WIP_POLL_EN
      ST_POLL: w_tx = (w_byte_nxt == 2'd0) ? OP_RDSR : 8'h00;
`endif
      default: w_tx = 8'h00;
    endcase
    w_cs_d = !is_cmd_state(w_state_nxt);
  end

  spi_byte_shifter u_shifter (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_start (w_start),
    .i_data  (w_tx),
`ifdef SPI_SE_WIP_POLL_EN
    .i_miso  (spi_miso),
    .o_rx    (w_rx),
`endif
    .o_done  (w_done),
    .o_sclk  (w_sclk),
    .o_mosi  (w_mosi)
  );

  assign spi_sclk = w_sclk;
  assign spi_mosi = w_mosi;
  assign spi_cs   = r_cs;

endmodule

// File: tb/tb_spi_sector_erase_ctrl.sv
`timescale 1ns/1ps
// Bench for spi_sector_erase_ctrl: a table of expected cs-low windows
// (bit count, captured mosi value, setup/hold/deselect cycle counts) is
// compared after a normal run and again after a reset that aborts SE.
module tb_spi_sector_erase_ctrl;

  localparam logic [23:0] ADDR      = 24'hA5_0F_3C;  // non-zero so address bytes are distinguishable
  localparam int          START_DLY = 100;
  localparam int          DESEL_CYC = 5;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic spi_miso  = 1'b0;
  logic spi_sclk;
  logic spi_cs;
  logic spi_mosi;

  always #10 sys_clk = ~sys_clk;  // 50 MHz

  spi_sector_erase_ctrl #(
    .SECTOR_ADDR (ADDR),
    .START_DLY   (START_DLY),
    .DESEL_CYC   (DESEL_CYC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .spi_miso  (spi_miso),
    .spi_sclk  (spi_sclk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor, sampled mid-cycle ----------------
  int          cyc = 0;
  logic        p_cs = 1'b1;
  logic        p_sclk = 1'b0;
  int          win_bits = 0;
  logic [31:0] win_val = 32'h0;
  bit          got_first = 1'b0;
  int          t_fall = 0;
  int          t_rise_last = 0;
  int          t_sclk_fall = 0;
  int          hi_run = 0;
  int          n_sclk_rise = 0;
  int          n_cs_fall = 0;
  int          viol = 0;
  int          bad_run = 0;
  int          poll_fall = 0;
  int          q_bits[$];
  logic [31:0] q_val[$];
  int          q_setup[$];
  int          q_hold[$];
  int          q_gap[$];

  always @(negedge sys_clk) begin
    cyc++;
    if (spi_cs && (spi_sclk || spi_mosi)) viol++;
    if (p_cs && !spi_cs) begin
      n_cs_fall++;
      win_bits  = 0;
      win_val   = 32'h0;
      got_first = 1'b0;
      poll_fall = 0;
      q_gap.push_back(cyc - t_rise_last);
      t_fall = cyc;
    end
    if (!p_sclk && spi_sclk) begin
      n_sclk_rise++;
      if (!spi_cs) begin
        win_val = {win_val[30:0], spi_mosi};
        win_bits++;
        if (!got_first) begin
          got_first = 1'b1;
          q_setup.push_back(cyc - t_fall);
        end
      end
    end
    if (spi_sclk) begin
      hi_run++;
    end else if (p_sclk) begin
      if (hi_run != 2) bad_run++;
      hi_run = 0;
      t_sclk_fall = cyc;
      poll_fall++;
    end
    if (!p_cs && spi_cs) begin
      q_bits.push_back(win_bits);
      q_val.push_back(win_val);
      q_hold.push_back(cyc - t_sclk_fall);
      t_rise_last = cyc;
    end
    p_cs   = spi_cs;
    p_sclk = spi_sclk;
`ifdef SPI_SE_WIP_POLL_EN
    // Flash stand-in: WIP (and all status bits) read 1 for the opcode byte
    // and two status bytes of the third window, then 0.
    spi_miso = (q_bits.size() == 2) && !spi_cs && (poll_fall < 24);
`endif
  end

  // ---------------- expected windows ----------------
  typedef struct {
    string       name;
    int          nbits;
    logic [31:0] value;
    int          setup;
    int          hold;
    int          gap;
  } win_t;

  win_t exp_tbl[$];

  task automatic clear_mon();
    q_bits.delete();
    q_val.delete();
    q_setup.delete();
    q_hold.delete();
    q_gap.delete();
    bad_run = 0;
  endtask

  task automatic wait_windows(input int n, input int budget);
    int k;
    k = 0;
    while ((q_bits.size() < n) && (k < budget)) begin
      @(posedge sys_clk);
      k++;
    end
    checks++;
    if (q_bits.size() < n) begin
      errors++;
      $display("FAIL wait_windows: got %0d windows expected %0d", q_bits.size(), n);
    end
  endtask

  task automatic wait_falls(input int n, input int budget);
    int k;
    k = 0;
    while ((n_cs_fall < n) && (k < budget)) begin
      @(posedge sys_clk);
      k++;
    end
    checks++;
    if (n_cs_fall < n) begin
      errors++;
      $display("FAIL wait_falls: got %0d cs falls expected %0d", n_cs_fall, n);
    end
  endtask

  task automatic check_windows(input string tag);
    check({tag, "_nwin"}, q_bits.size(), exp_tbl.size());
    for (int i = 0; i < exp_tbl.size(); i++) begin
      if (i < q_bits.size()) begin
        check({tag, "_", exp_tbl[i].name, "_bits"}, q_bits[i], exp_tbl[i].nbits);
        check({tag, "_", exp_tbl[i].name, "_val"},  q_val[i],  exp_tbl[i].value);
        check({tag, "_", exp_tbl[i].name, "_hold"}, q_hold[i], exp_tbl[i].hold);
      end
      if (i < q_setup.size()) begin
        check({tag, "_", exp_tbl[i].name, "_setup"}, q_setup[i], exp_tbl[i].setup);
      end
      if ((i > 0) && (i < q_gap.size())) begin
        check({tag, "_", exp_tbl[i].name, "_gap"}, q_gap[i], exp_tbl[i].gap);
      end
    end
    check({tag, "_sclk_high_run"}, bad_run, 0);
  endtask

  initial begin
    int n;
    int r0;
    int f0;

    // cs falls one clock before phase 0 (sclk rises 3 clocks after cs),
    // cs rises one clock after the last sclk fall.
    exp_tbl.push_back('{"wren", 8,  32'h0000_0006,  3, 1, 0});
    exp_tbl.push_back('{"se",   32, {8'hD8, ADDR},  3, 1, DESEL_CYC});
`ifdef SPI_SE_WIP_POLL_EN
    exp_tbl.push_back('{"poll", 32, 32'h0500_0000,  3, 1, DESEL_CYC});
`endif

    // Reset held: outputs parked.
    sys_rst_n = 1'b0;
    #5;
    check("rst_cs_a",   32'(spi_cs),   32'd1);
    check("rst_sclk_a", 32'(spi_sclk), 32'd0);
    check("rst_mosi_a", 32'(spi_mosi), 32'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_cs_b",   32'(spi_cs),   32'd1);
    check("rst_sclk_b", 32'(spi_sclk), 32'd0);
    check("rst_mosi_b", 32'(spi_mosi), 32'd0);

    // Release and measure the start delay.
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    n = 0;
    while (spi_cs && (n < 1000)) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check("start_dly", n, START_DLY);

    wait_windows(exp_tbl.size(), 3000);
    check_windows("run1");

    // DONE is absorbing: no clocks, cs stays high.
    r0 = n_sclk_rise;
    f0 = n_cs_fall;
    repeat (3000) @(posedge sys_clk);
    #1;
    check("done_sclk_edges", n_sclk_rise - r0, 0);
    check("done_cs_falls",   n_cs_fall - f0,   0);
    check("done_cs_level",   32'(spi_cs),      32'd1);
    check("idle_bus_viol",   viol,             0);

    // Restart, then abort midway through the SE address bytes.
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    clear_mon();
    f0 = n_cs_fall;
    wait_falls(f0 + 2, 1000);
    repeat (60) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("abort_cs",   32'(spi_cs),   32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_mosi", 32'(spi_mosi), 32'd0);
    repeat (2) @(negedge sys_clk);
    #1;
    check("abort_nwin", q_bits.size(), 2);
    if (q_bits.size() == 2) begin
      check("abort_partial", 32'(q_bits[1] > 8 && q_bits[1] < 32), 32'd1);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    clear_mon();
    wait_windows(exp_tbl.size(), 3000);
    check_windows("run2");
    check("final_bus_viol", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sector_erase_ctrl.md
SPI_SECTOR_ERASE_CTRL -- requirements
Module: spi_sector_erase_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does (sys_clk, sys_rst_n).
REQ-002 Parameter SECTOR_ADDR, default 24'h00_0000, SHALL set the 24-bit erase address, sent MSB first.
REQ-003 Parameter START_DLY, default 100, SHALL set the sys_clk cycles from reset release to the first chip-select assertion.
REQ-004 Parameter DESEL_CYC, default 5, SHALL set the sys_clk cycles spi_cs stays high between commands (100 ns at 50 MHz, meeting tSHSL).
REQ-005 sys_clk  input  1  system clock, 50 MHz.
REQ-006 sys_rst_n  input  1  asynchronous active-low reset.
REQ-007 spi_miso  input  1  flash serial data out; used only with REQ-025.
REQ-008 spi_sclk  output  1  SPI clock, mode 0, idles low.
REQ-009 spi_cs  output  1  active-low chip select.
REQ-010 spi_mosi  output  1  serial data to flash, MSB first.

Function
REQ-011 The FSM SHALL have states IDLE, WREN, DESEL, SE and DONE, plus POLL when REQ-025 is enabled.
REQ-012 IDLE: count START_DLY cycles, then go to WREN.
REQ-013 A byte SHALL take 32 sys_clk cycles, 4 per bit, counted by a 2-bit phase counter.
REQ-014 Per bit: spi_mosi SHALL update at phase 0, spi_sclk SHALL be low in phases 0-1 and high in phases 2-3, giving sys_clk/4 = 12.5 MHz.
REQ-015 spi_cs SHALL fall one sys_clk before phase 0 of the first bit of each command.
REQ-016 spi_cs SHALL rise one sys_clk after the final phase 3 of each command.
REQ-017 WREN: send the one byte 8'h06, then go to DESEL.
REQ-018 DESEL: hold spi_cs high for DESEL_CYC cycles, then go to SE.
REQ-019 SE: send 8'hD8 then SECTOR_ADDR[23:16], [15:8], [7:0], 32 bits under one continuous spi_cs low, then go to DONE.
REQ-020 DONE: absorbing state; spi_cs=1, spi_sclk=0, spi_mosi=0; the erase is issued exactly once per reset.
REQ-021 spi_mosi SHALL be 0 whenever spi_cs is high.
REQ-022 spi_sclk SHALL never toggle while spi_cs is high.

Reset
REQ-023 While sys_rst_n=0: spi_cs=1, spi_sclk=0, spi_mosi=0, state=IDLE, and all counters cleared.
REQ-024 Reset asserted mid-command SHALL abort the command immediately (spi_cs high, so the flash discards it); on release the full sequence restarts from IDLE.

Configuration
REQ-025 Macro SPI_SE_WIP_POLL_EN SHALL select status polling.
- Defined: after SE deselect (DESEL_CYC cycles), enter POLL.
- POLL sends 8'h05 and then keeps spi_cs low, clocking further status bytes.
- spi_miso is sampled on the spi_sclk rising edge (phase 2).
- When the received byte has bit0 (WIP)=0, raise spi_cs and go to DONE.
- Not defined: SE goes directly to DONE, spi_miso is ignored, and no POLL logic exists.

Structure
REQ-026 A shared package SHALL hold the opcodes (WREN 8'h06, SE 8'hD8, RDSR 8'h05) and the state enum.
REQ-027 One sub-module, spi_byte_shifter, SHALL implement the 4-phase bit timing, the 8-bit shift-out and (with REQ-025) the shift-in.
- spi_byte_shifter has a start/done handshake.
- The top FSM sequences its bytes.

Verification
REQ-028 Reset held 20 ns: spi_cs=1, spi_sclk=0, spi_mosi=0 throughout reset.
REQ-029 Release reset: after 100 cycles, capture 8 sclk rising edges = 8'h06, then spi_cs high for at least 100 ns.
REQ-030 Continue: capture 32 bits = 32'hD8_000000 under a single spi_cs low window.
- The m25p16 model (preloaded with incrementing data) reports sector 0 erased: all bytes 0x00000-0x0FFFF = 8'hFF.
- Sector 1 data is unchanged.
REQ-031 Run 10 ms past DONE: zero spi_sclk edges and spi_cs constantly 1.
REQ-032 Pulse sys_rst_n low midway through the SE address bytes: spi_cs rises at once; after release, a fresh 06 / D8 000000 sequence follows.
REQ-033 With SPI_SE_WIP_POLL_EN: 8'h05 is seen after SE, and spi_cs stays low until the model's WIP clears, then DONE.
